// File: rtl/perf_counter_unit_pkg.sv
// perf_counter_unit_pkg: sizes, op-class codes, address map and read FSM states for the perf monitor.
package perf_counter_unit_pkg;
    localparam int NUM_ALUS    = 4;
    localparam int NUM_THREADS = 4;
    localparam int TID_W       = 3;
    localparam int CNT_W       = 32;
    localparam int OP_W        = 7;
    localparam int INC_W       = $clog2(NUM_ALUS + 1);

    localparam logic [OP_W-1:0] OP_JAL   = 7'd3;
    localparam logic [OP_W-1:0] OP_JALR  = 7'd4;
    localparam logic [OP_W-1:0] OP_BR_LO = 7'd5;
    localparam logic [OP_W-1:0] OP_BR_HI = 7'd10;

    typedef enum logic [3:0] {
        A_CYCLES    = 4'd0,
        A_ISSUE0    = 4'd1,
        A_ISSUE1    = 4'd2,
        A_ISSUE2    = 4'd3,
        A_ISSUE3    = 4'd4,
        A_TAKEN0    = 4'd5,
        A_TAKEN1    = 4'd6,
        A_TAKEN2    = 4'd7,
        A_TAKEN3    = 4'd8,
        A_SUM_ISSUE = 4'd9,
        A_SUM_TAKEN = 4'd10,
        A_OVF       = 4'd11
    } perf_addr_e;

    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DROP} rd_state_e;

    // Unconditional jumps always count; branches only when resolved taken.
    function automatic logic op_taken(input logic [OP_W-1:0] op, input logic jump);
        return (op >= OP_BR_LO && op <= OP_BR_HI && jump) || op == OP_JAL || op == OP_JALR;
    endfunction
endpackage

// File: rtl/perf_lane_tally.sv
// perf_lane_tally: per-thread count of valid and taken lanes in one dispatch cycle.
module perf_lane_tally
    import perf_counter_unit_pkg::*;
(
    input  logic [NUM_ALUS*TID_W-1:0]         i_lane_thread,
    input  logic [NUM_ALUS*OP_W-1:0]          i_lane_op,
    input  logic [NUM_ALUS-1:0]               i_lane_jump,
    output logic [NUM_THREADS-1:0][INC_W-1:0] o_issue,
    output logic [NUM_THREADS-1:0][INC_W-1:0] o_taken
);
    // Thread ids outside 0..NUM_THREADS-1 never match, so idle lanes drop out here.
    always_comb begin
        o_issue = '0;
        o_taken = '0;
        for (int l = 0; l < NUM_ALUS; l++) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (i_lane_thread[l*TID_W +: TID_W] == TID_W'(t) && i_lane_op[l*OP_W +: OP_W] != '0) begin
                    o_issue[t] = o_issue[t] + INC_W'(1);
                    o_taken[t] = o_taken[t] + INC_W'(op_taken(i_lane_op[l*OP_W +: OP_W], i_lane_jump[l]));
                end
            end
        end
    end
endmodule

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: live cycle/issue/taken counters, snapshot bank and req/ack read port.
// Optional PERF_OVF_IRQ_EN adds sticky wrap flags, ovf_irq and flag readout at address 11.
module perf_counter_unit
    import perf_counter_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_cnt_en,
    input  logic [NUM_ALUS*TID_W-1:0] i_lane_thread,
    input  logic [NUM_ALUS*OP_W-1:0]  i_lane_op,
    input  logic [NUM_ALUS-1:0]       i_lane_jump,
    input  logic                      i_snap_req,
    input  logic                      i_clr_req,
    input  logic                      i_rd_req,
    input  logic [3:0]                i_rd_addr,
    output logic                      o_rd_ack,
    output logic [CNT_W-1:0]          o_rd_data,
    output logic                      o_ovf_irq
);
`ifdef PERF_OVF_IRQ_EN
    localparam int XW = CNT_W + 1;
`else
    localparam int XW = CNT_W;
`endif

    logic [NUM_THREADS-1:0][INC_W-1:0] w_issue, w_taken;
    logic [CNT_W-1:0]                  r_cycles, r_sh_cycles;
    logic [NUM_THREADS-1:0][CNT_W-1:0] r_issue, r_taken, r_sh_issue, r_sh_taken;
    logic [XW-1:0]                     w_cyc_nxt;
    logic [NUM_THREADS-1:0][XW-1:0]    w_iss_nxt, w_tkn_nxt;
    logic [CNT_W-1:0]                  w_sum_issue, w_sum_taken, w_rd_val, w_ovf_word, r_rd_data;
    logic [1:0]                        w_idx;
    logic                              w_rd_load;
    rd_state_e                         r_state, w_state;

    perf_lane_tally u_tally (
        .i_lane_thread(i_lane_thread),
        .i_lane_op    (i_lane_op),
        .i_lane_jump  (i_lane_jump),
        .o_issue      (w_issue),
        .o_taken      (w_taken)
    );

    // One spare bit above the counter carries the wrap-out when overflow flags are built.
    always_comb begin
        w_cyc_nxt = XW'(r_cycles) + XW'(1);
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_iss_nxt[t] = XW'(r_issue[t]) + XW'(w_issue[t]);
            w_tkn_nxt[t] = XW'(r_taken[t]) + XW'(w_taken[t]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || i_clr_req) begin
            r_cycles <= '0;
            r_issue  <= '0;
            r_taken  <= '0;
        end else if (i_cnt_en) begin
            r_cycles <= w_cyc_nxt[CNT_W-1:0];
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_issue[t] <= w_iss_nxt[t][CNT_W-1:0];
                r_taken[t] <= w_tkn_nxt[t][CNT_W-1:0];
            end
        end
    end

    // Shadow copies the registered live values, so a same-cycle clear still snaps pre-clear counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh_cycles <= '0;
            r_sh_issue  <= '0;
            r_sh_taken  <= '0;
        end else if (i_snap_req) begin
            r_sh_cycles <= r_cycles;
            r_sh_issue  <= r_issue;
            r_sh_taken  <= r_taken;
        end
    end

    always_comb begin
        w_sum_issue = '0;
        w_sum_taken = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_sum_issue = w_sum_issue + r_sh_issue[t];
            w_sum_taken = w_sum_taken + r_sh_taken[t];
        end
    end

    // Issue and taken banks both start at an address whose low bits are 01.
    assign w_idx = i_rd_addr[1:0] - 2'd1;

    always_comb begin
        case (perf_addr_e'(i_rd_addr))
            A_CYCLES:                               w_rd_val = r_sh_cycles;
            A_ISSUE0, A_ISSUE1, A_ISSUE2, A_ISSUE3: w_rd_val = r_sh_issue[w_idx];
            A_TAKEN0, A_TAKEN1, A_TAKEN2, A_TAKEN3: w_rd_val = r_sh_taken[w_idx];
            A_SUM_ISSUE:                            w_rd_val = w_sum_issue;
            A_SUM_TAKEN:                            w_rd_val = w_sum_taken;
            A_OVF:                                  w_rd_val = w_ovf_word;
            default:                                w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= w_state;
    end

    always_comb begin
        w_state   = r_state;
        w_rd_load = 1'b0;
        case (r_state)
            R_IDLE: begin
                w_rd_load = i_rd_req;
                w_state   = i_rd_req ? R_ACK : R_IDLE;
            end
            R_ACK:   w_state = R_DROP;
            default: w_state = i_rd_req ? R_DROP : R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)           r_rd_data <= '0;
        else if (w_rd_load) r_rd_data <= w_rd_val;
    end

    assign o_rd_ack  = (r_state == R_ACK);
    assign o_rd_data = r_rd_data;

`ifdef PERF_OVF_IRQ_EN
    logic [2*NUM_THREADS:0] r_ovf, w_ovf_set;
    logic [NUM_THREADS-1:0] w_iss_c, w_tkn_c;
    logic                   w_ovf_rd;

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_iss_c[t] = w_iss_nxt[t][CNT_W];
            w_tkn_c[t] = w_tkn_nxt[t][CNT_W];
        end
    end

    assign w_ovf_set = {w_tkn_c, w_iss_c, w_cyc_nxt[CNT_W]};
    assign w_ovf_rd  = w_rd_load && i_rd_addr == A_OVF;

    // A wrap in the same cycle as the flag read survives, since it was not part of the read value.
    always_ff @(posedge clk) begin
        if (!rst || i_clr_req) r_ovf <= '0;
        else                   r_ovf <= (w_ovf_rd ? '0 : r_ovf) | (i_cnt_en ? w_ovf_set : '0);
    end

    assign w_ovf_word = CNT_W'(r_ovf);
    assign o_ovf_irq  = |r_ovf;
`else
    assign w_ovf_word = '0;
    assign o_ovf_irq  = 1'b0;
`endif
endmodule
